// File: rtl/pc_unit_ras.sv
// Program-counter unit with an internal return-address stack.
// Handles sequential fetch, relative branch, absolute jump, call/return,
// stall, and sticky overflow/underflow/misalignment flags.
module pc_unit_ras #(
    parameter int unsigned     XLEN         = 64,
    parameter int unsigned     INSTR_BYTES  = 4,
    parameter int unsigned     RAS_DEPTH    = 8,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       redirect_valid,
    input  logic [1:0]                 redirect_mode,
    input  logic [XLEN-1:0]            offset,
    input  logic [XLEN-1:0]            target,
    input  logic                       clear_err,
    output logic [XLEN-1:0]            pc,
    output logic [XLEN-1:0]            pc_seq,
    output logic [XLEN-1:0]            ras_top,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_overflow,
    output logic                       ras_underflow,
    output logic                       misaligned
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;
    // Low address bits that must be zero; an all-zero mask disables the check.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

    typedef enum logic [1:0] {
        MODE_BRANCH = 2'b00,
        MODE_JUMP   = 2'b01,
        MODE_CALL   = 2'b10,
        MODE_RETURN = 2'b11
    } mode_e;

    mode_e           mode;
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   top_idx;
    logic            ras_full;
    logic [XLEN-1:0] raw_target;
    logic [XLEN-1:0] pc_next;
    logic            push;
    logic            pop;
    logic            set_ovf;
    logic            set_unf;
    logic            set_mis;

    assign mode     = mode_e'(redirect_mode);
    // wr_ptr is the next slot to write; when full it also points at the
    // oldest entry, so a push overwrites it without extra bookkeeping.
    assign top_idx  = wr_ptr - PW'(1);
    assign ras_full = (ras_count == CW'(RAS_DEPTH));
    assign pc_seq   = pc + XLEN'(INSTR_BYTES);
    assign ras_top  = (ras_count != '0) ? ras_mem[top_idx] : '0;

    // Select the next pc and the stack/flag actions for this edge.
    always_comb begin
        raw_target = '0;
        pc_next    = pc_seq;
        push       = 1'b0;
        pop        = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        set_mis    = 1'b0;
        if (redirect_valid) begin
            case (mode)
                MODE_BRANCH: raw_target = pc + offset;
                MODE_JUMP:   raw_target = target;
                MODE_CALL: begin
                    raw_target = pc + offset;
                    push       = 1'b1;
                    set_ovf    = ras_full;
                end
                MODE_RETURN: begin
                    if (ras_count != '0) begin
                        raw_target = ras_top;
                        pop        = 1'b1;
                    end else begin
                        raw_target = target;
                        set_unf    = 1'b1;
                    end
                end
                default: raw_target = target;
            endcase
            set_mis = |(raw_target & ALIGN_MASK);
            pc_next = raw_target & ~ALIGN_MASK;
        end
        if (stall) begin
            pc_next = pc;
            push    = 1'b0;
            pop     = 1'b0;
            set_ovf = 1'b0;
            set_unf = 1'b0;
            set_mis = 1'b0;
        end
    end

    // Register pc, stack contents/pointer/count and sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc            <= RESET_VECTOR;
            wr_ptr        <= '0;
            ras_count     <= '0;
            ras_mem       <= '{default: '0};
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            misaligned    <= 1'b0;
        end else begin
            pc <= pc_next;
            if (push) begin
                ras_mem[wr_ptr] <= pc_seq;
                wr_ptr          <= wr_ptr + PW'(1);
                if (!ras_full) begin
                    ras_count <= ras_count + CW'(1);
                end
            end else if (pop) begin
                wr_ptr    <= top_idx;
                ras_count <= ras_count - CW'(1);
            end
            // Setting events take precedence over a same-edge clear.
            ras_overflow  <= (ras_overflow  & ~clear_err) | set_ovf;
            ras_underflow <= (ras_underflow & ~clear_err) | set_unf;
            misaligned    <= (misaligned    & ~clear_err) | set_mis;
        end
    end

endmodule

// File: tb/tb_pc_unit_ras.sv
// Self-checking bench for pc_unit_ras: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_pc_unit_ras;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall, rv, clr;
    logic [1:0]  mode;
    logic [63:0] off, tgt;
    logic [63:0] pc, pc_seq, ras_top;
    logic [3:0]  ras_count;
    logic        ovf, unf, mis;

    logic        rv32;
    logic [1:0]  mode32;
    logic [31:0] tgt32;
    logic [31:0] pc32, pc_seq32, ras_top32;
    logic [3:0]  ras_count32;
    logic        ovf32, unf32, mis32;

    pc_unit_ras dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(rv),
        .redirect_mode(mode), .offset(off), .target(tgt), .clear_err(clr),
        .pc(pc), .pc_seq(pc_seq), .ras_top(ras_top), .ras_count(ras_count),
        .ras_overflow(ovf), .ras_underflow(unf), .misaligned(mis)
    );

    pc_unit_ras #(.XLEN(32), .INSTR_BYTES(2), .RAS_DEPTH(8), .RESET_VECTOR(32'h0)) u32 (
        .clk(clk), .rst(rst), .stall(1'b0), .redirect_valid(rv32),
        .redirect_mode(mode32), .offset(32'h0), .target(tgt32), .clear_err(1'b0),
        .pc(pc32), .pc_seq(pc_seq32), .ras_top(ras_top32), .ras_count(ras_count32),
        .ras_overflow(ovf32), .ras_underflow(unf32), .misaligned(mis32)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: pc value, stack as a queue (back = top), flags.
    logic [63:0] m_pc;
    logic [63:0] m_ras[$];
    logic        m_ovf, m_unf, m_mis;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 64'h0;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_mis = 1'b0;
    endtask

    task automatic model_step();
        logic [63:0] t;
        logic so, su, sm;
        so = 1'b0; su = 1'b0; sm = 1'b0;
        t  = m_pc + 64'd4;
        if (!stall) begin
            if (rv) begin
                if (mode == 2'd0) t = m_pc + off;
                else if (mode == 2'd1) t = tgt;
                else if (mode == 2'd2) begin
                    t = m_pc + off;
                    if (m_ras.size() == 8) begin
                        void'(m_ras.pop_front());
                        so = 1'b1;
                    end
                    m_ras.push_back(m_pc + 64'd4);
                end else begin
                    if (m_ras.size() > 0) t = m_ras.pop_back();
                    else begin
                        t  = tgt;
                        su = 1'b1;
                    end
                end
                if (t % 4 != 0) begin
                    sm = 1'b1;
                    t  = t - (t % 4);
                end
            end
            m_pc = t;
        end
        if (clr) begin
            m_ovf = 1'b0; m_unf = 1'b0; m_mis = 1'b0;
        end
        if (so) m_ovf = 1'b1;
        if (su) m_unf = 1'b1;
        if (sm) m_mis = 1'b1;
    endtask

    task automatic compare_all(input string where);
        check({where, ".pc"}, pc, m_pc);
        check({where, ".pc_seq"}, pc_seq, m_pc + 64'd4);
        check({where, ".ras_count"}, {60'd0, ras_count}, 64'(m_ras.size()));
        check({where, ".ras_top"}, ras_top, (m_ras.size() > 0) ? m_ras[$] : 64'h0);
        check({where, ".flags"}, {61'd0, ovf, unf, mis}, {61'd0, m_ovf, m_unf, m_mis});
    endtask

    task automatic step(input string where, input logic s, input logic v, input logic [1:0] md,
                        input logic [63:0] o, input logic [63:0] t, input logic c);
        stall = s; rv = v; mode = md; off = o; tgt = t; clr = c;
        model_step();
        @(posedge clk);
        #1;
        compare_all(where);
    endtask

    initial begin
        logic [63:0] ro;
        stall = 0; rv = 0; mode = 0; off = 0; tgt = 0; clr = 0;
        rv32 = 0; mode32 = 0; tgt32 = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #3;
        model_reset();
        compare_all("reset");
        rst = 1'b1;

        // Sequential fetch
        for (int k = 0; k < 10; k++) step("seq", 0, 0, 0, 0, 0, 0);
        check("seq_end_pc", pc, 64'd40);

        // Forward/backward branch and wrap
        step("br_fwd", 0, 1, 2'd0, 64'd1000, 0, 0);
        check("br_fwd_lit", pc, 64'd1040);
        step("br_back", 0, 1, 2'd0, -64'sd100, 0, 0);
        check("br_back_lit", pc, 64'd940);
        step("br_next", 0, 0, 0, 0, 0, 0);
        check("br_next_lit", pc, 64'd944);
        step("jmp0", 0, 1, 2'd1, 0, 64'd0, 0);
        step("br_wrap", 0, 1, 2'd0, -64'sd4, 0, 0);
        check("br_wrap_lit", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step("self_loop", 0, 1, 2'd0, 64'd0, 0, 0);

        // Call/return nesting
        step("jmp100", 0, 1, 2'd1, 0, 64'd100, 0);
        step("call1", 0, 1, 2'd2, 64'd400, 0, 0);
        step("call2", 0, 1, 2'd2, 64'd100, 0, 0);
        check("nest_count", {60'd0, ras_count}, 64'd2);
        check("nest_top", ras_top, 64'd504);
        step("ret1", 0, 1, 2'd3, 0, 0, 0);
        check("ret1_lit", pc, 64'd504);
        step("ret2", 0, 1, 2'd3, 0, 0, 0);
        check("ret2_lit", pc, 64'd104);

        // Overflow / underflow / clear
        for (int k = 0; k < 9; k++) step("call_ovf", 0, 1, 2'd2, 64'd8, 0, 0);
        check("ovf_count", {60'd0, ras_count}, 64'd8);
        check("ovf_flag", {63'd0, ovf}, 64'd1);
        for (int k = 0; k < 8; k++) step("ret_ovf", 0, 1, 2'd3, 0, 64'h200, 0);
        step("ret_unf", 0, 1, 2'd3, 0, 64'h200, 0);
        check("unf_pc_lit", pc, 64'h200);
        check("unf_flag", {63'd0, unf}, 64'd1);
        step("clear", 0, 0, 0, 0, 0, 1);

        // Stall and misalignment
        for (int k = 0; k < 3; k++) step("stall", 1, 1, 2'd1, 0, 64'h300, 0);
        step("mis_jmp", 0, 1, 2'd1, 0, 64'h302, 0);
        check("mis_pc_lit", pc, 64'h300);
        check("mis_flag", {63'd0, mis}, 64'd1);
        step("clr_vs_set", 0, 1, 2'd1, 0, 64'h305, 1);
        step("stall_clr", 1, 1, 2'd1, 0, 64'h401, 1);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            ro = 64'($signed($urandom_range(0, 500)) - 250) * 4;
            if ($urandom_range(0, 7) == 0) ro = ro + 64'($urandom_range(1, 3));
            step("rand", ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)), ro,
                 {32'($urandom), 32'($urandom)}, ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset during a call cycle
        step("pre_call", 0, 1, 2'd2, 64'd64, 0, 0);
        stall = 0; rv = 1; mode = 2'd2; off = 64'd64; clr = 0;
        #2 rst = 1'b0;
        #1;
        check("arst_pc", pc, 64'h0);
        check("arst_count", {60'd0, ras_count}, 64'd0);
        check("arst_top", ras_top, 64'h0);
        check("arst_pc32", {32'd0, pc32}, 64'h0);
        rst = 1'b1;
        model_reset();

        // 32-bit, 2-byte instance: sequential steps and wrap at 2^32
        for (int k = 1; k <= 10; k++) begin
            step("seq_after_rst", 0, 0, 0, 0, 0, 0);
            check("seq32_pc", {32'd0, pc32}, 64'(2 * k));
            check("seq32_pc_seq", {32'd0, pc_seq32}, 64'(2 * k + 2));
        end
        rv32 = 1; mode32 = 2'd1; tgt32 = 32'hFFFF_FFFC;
        step("idle", 0, 0, 0, 0, 0, 0);
        check("jmp32_pc", {32'd0, pc32}, 64'hFFFF_FFFC);
        rv32 = 0;
        step("idle", 0, 0, 0, 0, 0, 0);
        check("seq32_top", {32'd0, pc32}, 64'hFFFF_FFFE);
        check("seq32_top_seq", {32'd0, pc_seq32}, 64'h0);
        step("idle", 0, 0, 0, 0, 0, 0);
        check("wrap32_pc", {32'd0, pc32}, 64'h0);
        rv32 = 1; tgt32 = 32'h5;
        step("idle", 0, 0, 0, 0, 0, 0);
        check("mis32_pc", {32'd0, pc32}, 64'h4);
        check("mis32_flag", {63'd0, mis32}, 64'd1);
        rv32 = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
